// File: rtl/uram_sched_pkg.sv
// -----------------------------------------------------------------------------
// uram_sched_pkg
//   Shared types and constants for the URAM port scheduler.
//   - sched_state_t : scheduler FSM state (zero-fill, then normal operation)
//   - grant_src_t   : which requester owns a bank port in the current cycle
//   - FILL_VALUE    : bit value replicated across a word during zero-fill
//   - PERF_WIDTH    : width of the host stall performance counter
// -----------------------------------------------------------------------------
package uram_sched_pkg;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } sched_state_t;

   // Port ownership per cycle. The muxes in the top are driven from this,
   // so it doubles as a convenient debug probe.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_FILL = 2'd1,
      SRC_CORE = 2'd2,
      SRC_HOST = 2'd3
   } grant_src_t;

   localparam logic FILL_VALUE = '0;
   localparam int   PERF_WIDTH = 32;

endpackage : uram_sched_pkg

// File: rtl/uram_rsp_hold.sv
// -----------------------------------------------------------------------------
// uram_rsp_hold
//   Host read response path. A read accepted in cycle N returns the bank
//   output directly in N+1; if the host is not ready in N+1, the word is
//   captured and replayed until the host consumes it.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   issue        : host read accepted this cycle
//   mem_dout     : bank read data (valid the cycle after issue)
//   rready       : host consumes the response this cycle
//   rvalid       : response valid
//   rdata        : response data (0 when no response is valid)
// -----------------------------------------------------------------------------
module uram_rsp_hold #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  issue,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   input  logic                  rready,
   output logic                  rvalid,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic                  inflight_q, inflight_d;
   logic                  held_q, held_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;

   // inflight and held are mutually exclusive: a new read is only issued
   // when no response is pending or the pending one is consumed now.
   always_comb begin
      inflight_d  = issue;
      held_d      = held_q;
      hold_data_d = hold_data_q;
      if (inflight_q && !rready) begin
         held_d      = 1'b1;
         hold_data_d = mem_dout;
      end else if (held_q && rready) begin
         held_d = 1'b0;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inflight_q <= 1'b0;
         held_q     <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         held_q     <= held_d;
      end
   end

   // NOTE: the data register has no reset; it is only observed while held_q
   // is set, so clearing it would buy nothing but reset fan-out.
   always_ff @(posedge clock) begin
      hold_data_q <= hold_data_d;
   end

   assign rvalid = inflight_q | held_q;
   assign rdata  = held_q     ? hold_data_q :
                   inflight_q ? mem_dout    : '0;

endmodule : uram_rsp_hold

// File: rtl/uram_port_scheduler.sv
// -----------------------------------------------------------------------------
// uram_port_scheduler
//   Shares one simple-dual-port URAM bank (1 write port, 1 read port,
//   1-cycle registered read, read-first) between a core pipeline (fixed
//   priority, no backpressure) and a host port (valid/ready). After reset
//   the whole bank is zero-filled before any access is granted.
//
// Optional build macro:
//   URAM_SCHED_PERF_EN : when defined, host_stall_cycles counts RUN cycles
//                        with host_valid & !host_ready (saturating). When
//                        undefined, host_stall_cycles is tied to 0.
//
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   init_done             : zero-fill complete
//   core_ren/raddr        : core read request; core_rvalid/core_rdata return
//                           one cycle later with no hold
//   core_wen/waddr/wdata  : core write request
//   host_valid/ready/we/addr/wdata : host request channel (we=1 write)
//   host_rvalid/rready/rdata       : host read response channel
//   mem_wen/waddr/din     : bank write port
//   mem_raddr/mem_dout    : bank read port (dout valid 1 cycle after raddr)
//   host_stall_cycles     : host stall performance counter
// -----------------------------------------------------------------------------
module uram_port_scheduler
   import uram_sched_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int ADDRESS_WIDTH = 12
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic                     init_done,
   input  logic                     core_ren,
   input  logic [ADDRESS_WIDTH-1:0] core_raddr,
   output logic                     core_rvalid,
   output logic [DATA_WIDTH-1:0]    core_rdata,
   input  logic                     core_wen,
   input  logic [ADDRESS_WIDTH-1:0] core_waddr,
   input  logic [DATA_WIDTH-1:0]    core_wdata,
   input  logic                     host_valid,
   output logic                     host_ready,
   input  logic                     host_we,
   input  logic [ADDRESS_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0]    host_wdata,
   output logic                     host_rvalid,
   input  logic                     host_rready,
   output logic [DATA_WIDTH-1:0]    host_rdata,
   output logic                     mem_wen,
   output logic [ADDRESS_WIDTH-1:0] mem_waddr,
   output logic [DATA_WIDTH-1:0]    mem_din,
   output logic [ADDRESS_WIDTH-1:0] mem_raddr,
   input  logic [DATA_WIDTH-1:0]    mem_dout,
   output logic [PERF_WIDTH-1:0]    host_stall_cycles
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

   sched_state_t             state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] fill_q, fill_d;
   logic                     init_done_q, init_done_d;
   logic                     core_rvalid_q, core_rvalid_d;
   logic                     host_wr_acc, host_rd_acc;
   logic                     rsp_valid;
   grant_src_t               wr_src, rd_src;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d       = state_q;
      fill_d        = fill_q;
      init_done_d   = init_done_q;
      core_rvalid_d = core_ren && (state_q == RUN);
      case (state_q)
         INIT: begin
            // Counter wraps back to 0 on the last address, leaving it clean.
            fill_d = fill_q + ADDRESS_WIDTH'(1);
            if (fill_q == LAST_ADDR) begin
               state_d     = RUN;
               init_done_d = 1'b1;
            end
         end
         RUN: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= INIT;
         fill_q        <= '0;
         init_done_q   <= 1'b0;
         core_rvalid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fill_q        <= fill_d;
         init_done_q   <= init_done_d;
         core_rvalid_q <= core_rvalid_d;
      end
   end

   // ------------------------------------------------------- host accept
   // rsp_valid comes from flops, so host_ready has no path back onto itself.
   always_comb begin
      host_wr_acc = 1'b0;
      host_rd_acc = 1'b0;
      if (state_q == RUN) begin
         host_wr_acc = host_valid && host_we && !core_wen;
         host_rd_acc = host_valid && !host_we && !core_ren &&
                       (!rsp_valid || host_rready);
      end
   end

   assign host_ready = host_wr_acc | host_rd_acc;

   // ------------------------------------------------ port ownership / mux
   always_comb begin
      wr_src = SRC_NONE;
      rd_src = SRC_NONE;
      if (state_q == INIT) begin
         wr_src = SRC_FILL;
         rd_src = SRC_FILL;
      end else begin
         if (core_wen)         wr_src = SRC_CORE;
         else if (host_wr_acc) wr_src = SRC_HOST;
         if (core_ren)         rd_src = SRC_CORE;
         else if (host_rd_acc) rd_src = SRC_HOST;
      end
   end

   // NOTE: every output of this block gets a default before the case, so an
   // unlisted path can never hold a stale value and infer a latch.
   always_comb begin
      mem_wen   = 1'b0;
      mem_waddr = '0;
      mem_din   = '0;
      mem_raddr = '0;
      unique case (wr_src)
         SRC_NONE: ;
         SRC_FILL: begin
            mem_wen   = 1'b1;
            mem_waddr = fill_q;
            mem_din   = {DATA_WIDTH{FILL_VALUE}};
         end
         SRC_CORE: begin
            mem_wen   = 1'b1;
            mem_waddr = core_waddr;
            mem_din   = core_wdata;
         end
         SRC_HOST: begin
            mem_wen   = 1'b1;
            mem_waddr = host_addr;
            mem_din   = host_wdata;
         end
      endcase
      unique case (rd_src)
         SRC_NONE, SRC_FILL: ;
         SRC_CORE: mem_raddr = core_raddr;
         SRC_HOST: mem_raddr = host_addr;
      endcase
   end

   // ------------------------------------------------------ read returns
   assign init_done   = init_done_q;
   assign core_rvalid = core_rvalid_q;
   assign core_rdata  = core_rvalid_q ? mem_dout : '0;

   uram_rsp_hold #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_rsp_hold (
      .clock    (clock),
      .reset    (reset),
      .issue    (host_rd_acc),
      .mem_dout (mem_dout),
      .rready   (host_rready),
      .rvalid   (rsp_valid),
      .rdata    (host_rdata)
   );

   assign host_rvalid = rsp_valid;

   // ---------------------------------------------- host stall counter
`ifdef URAM_SCHED_PERF_EN
   logic [PERF_WIDTH-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((state_q == RUN) && host_valid && !host_ready && (stall_q != '1)) begin
         stall_d = stall_q + PERF_WIDTH'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign host_stall_cycles = stall_q;
`else
   assign host_stall_cycles = '0;
`endif

endmodule : uram_port_scheduler

// File: tb/tb_uram_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uram_port_scheduler
//   Self-checking bench for uram_port_scheduler with a 16-word bank. A
//   behavioural bank (read-first, registered read) sits on the mem_* ports.
//   A reference model tracks bank contents, the expected core return and the
//   single outstanding host response from the request rules alone.
// -----------------------------------------------------------------------------
module tb_uram_port_scheduler;

   localparam int DW    = 64;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   localparam logic [AW-1:0] CW = 4'd3;  // core write address in table
   localparam logic [AW-1:0] CR = 4'd4;  // core read address in table
   localparam logic [AW-1:0] HA = 4'd9;  // host address in table

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          init_done;
   logic          core_ren = 1'b0;
   logic [AW-1:0] core_raddr = '0;
   logic          core_rvalid;
   logic [DW-1:0] core_rdata;
   logic          core_wen = 1'b0;
   logic [AW-1:0] core_waddr = '0;
   logic [DW-1:0] core_wdata = '0;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic          host_we = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          host_rvalid;
   logic          host_rready = 1'b1;
   logic [DW-1:0] host_rdata;
   logic          mem_wen;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_din;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_dout = '0;
   logic [31:0]   host_stall_cycles;

   uram_port_scheduler #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .init_done         (init_done),
      .core_ren          (core_ren),
      .core_raddr        (core_raddr),
      .core_rvalid       (core_rvalid),
      .core_rdata        (core_rdata),
      .core_wen          (core_wen),
      .core_waddr        (core_waddr),
      .core_wdata        (core_wdata),
      .host_valid        (host_valid),
      .host_ready        (host_ready),
      .host_we           (host_we),
      .host_addr         (host_addr),
      .host_wdata        (host_wdata),
      .host_rvalid       (host_rvalid),
      .host_rready       (host_rready),
      .host_rdata        (host_rdata),
      .mem_wen           (mem_wen),
      .mem_waddr         (mem_waddr),
      .mem_din           (mem_din),
      .mem_raddr         (mem_raddr),
      .mem_dout          (mem_dout),
      .host_stall_cycles (host_stall_cycles)
   );

   always #5 clock = ~clock;

   // Behavioural bank: registered read, read-first on same-address collision.
   logic [DW-1:0] bank [DEPTH];
   always @(posedge clock) begin
      mem_dout <= bank[mem_raddr];
      if (mem_wen) bank[mem_waddr] <= mem_din;
   end

   // ------------------------------------------------------------- checking
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   logic [DW-1:0] ref_mem [DEPTH];
   bit            m_run;
   int            m_fill;
   bit            m_core_v;
   logic [DW-1:0] m_core_d;
   bit            m_rsp_v;
   logic [DW-1:0] m_rsp_d;
   longint        m_stall;

   task automatic model_reset();
      m_run    = 1'b0;
      m_fill   = 0;
      m_core_v = 1'b0;
      m_core_d = '0;
      m_rsp_v  = 1'b0;
      m_rsp_d  = '0;
      m_stall  = 0;
   endtask

   // Called at posedge+1 with this cycle's inputs already applied. Checks all
   // outputs against the model, advances the model, and returns at the next
   // posedge+1.
   task automatic cycle();
      bit            e_hw, e_hr, e_ready, e_wen, e_rd;
      logic [AW-1:0] e_waddr, e_raddr;
      logic [DW-1:0] e_din;
      bit            n_core_v;
      logic [DW-1:0] n_core_d;
      #1;
      check("init_done", init_done, m_run);
      check("core_rvalid", core_rvalid, m_core_v);
      if (m_core_v) check("core_rdata", core_rdata, m_core_d);
      check("host_rvalid", host_rvalid, m_rsp_v);
      if (m_rsp_v) check("host_rdata", host_rdata, m_rsp_d);
`ifdef URAM_SCHED_PERF_EN
      check("host_stall_cycles", host_stall_cycles, 64'(m_stall));
`else
      check("host_stall_cycles", host_stall_cycles, '0);
`endif
      e_hw = 1'b0;
      e_hr = 1'b0;
      if (!m_run) begin
         e_wen   = 1'b1;
         e_waddr = AW'(m_fill);
         e_din   = '0;
         e_rd    = 1'b1;
         e_raddr = '0;
      end else begin
         e_hw    = host_valid && host_we && !core_wen;
         e_hr    = host_valid && !host_we && !core_ren && (!m_rsp_v || host_rready);
         e_wen   = core_wen || e_hw;
         e_waddr = core_wen ? core_waddr : host_addr;
         e_din   = core_wen ? core_wdata : host_wdata;
         e_rd    = core_ren || e_hr;
         e_raddr = core_ren ? core_raddr : host_addr;
      end
      e_ready = e_hw || e_hr;
      check("host_ready", host_ready, e_ready);
      check("mem_wen", mem_wen, e_wen);
      if (e_wen) begin
         check("mem_waddr", mem_waddr, e_waddr);
         check("mem_din", mem_din, e_din);
      end
      if (e_rd) check("mem_raddr", mem_raddr, e_raddr);

      // Advance the model: reads see the bank before this cycle's write.
      n_core_v = m_run && core_ren;
      n_core_d = ref_mem[core_raddr];
      if (m_run && host_valid && !e_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_rsp_v && host_rready) m_rsp_v = 1'b0;
      if (e_hr) begin
         m_rsp_v = 1'b1;
         m_rsp_d = ref_mem[host_addr];
      end
      if (e_wen) ref_mem[e_waddr] = e_din;
      m_core_v = n_core_v;
      m_core_d = n_core_d;
      if (!m_run) begin
         m_fill++;
         if (m_fill == DEPTH) m_run = 1'b1;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      core_ren   = 1'b0;
      core_wen   = 1'b0;
      host_valid = 1'b0;
      host_we    = 1'b0;
   endtask

   // ------------------------------------------------------- table vectors
   typedef struct {
      bit            c_ren;
      bit            c_wen;
      bit            h_valid;
      bit            h_we;
      bit            e_ready;
      bit            e_wen;
      logic [AW-1:0] e_waddr;
      bit            e_rd;
      logic [AW-1:0] e_raddr;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 0, 0, 0,  0, 0, 0,  0, 0};
      vecs[1] = '{0, 0, 1, 1,  1, 1, HA, 0, 0};
      vecs[2] = '{0, 1, 1, 1,  0, 1, CW, 0, 0};
      vecs[3] = '{0, 0, 1, 0,  1, 0, 0,  1, HA};
      vecs[4] = '{1, 0, 1, 0,  0, 0, 0,  1, CR};
      vecs[5] = '{0, 1, 1, 0,  1, 1, CW, 1, HA};
      vecs[6] = '{1, 0, 1, 1,  1, 1, HA, 1, CR};
      vecs[7] = '{1, 1, 0, 0,  0, 1, CW, 1, CR};
      vecs[8] = '{1, 1, 1, 1,  0, 1, CW, 1, CR};
      vecs[9] = '{1, 1, 1, 0,  0, 1, CW, 1, CR};

      // ---------------------------------------------------- reset state
      host_valid = 1'b1;
      @(posedge clock);
      #1;
      check("rst init_done", init_done, 0);
      check("rst host_ready", host_ready, 0);
      check("rst core_rvalid", core_rvalid, 0);
      check("rst host_rvalid", host_rvalid, 0);
      check("rst mem_wen", mem_wen, 1);
      check("rst mem_waddr", mem_waddr, 0);
      check("rst mem_din", mem_din, 0);
      check("rst mem_raddr", mem_raddr, 0);
      check("rst core_rdata", core_rdata, 0);
      check("rst host_rdata", host_rdata, 0);
      check("rst stall", host_stall_cycles, 0);

      // ------------------------------------------------------ zero-fill
      // Requests during fill must be ignored and not counted as stalls.
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         core_ren   = 1'b1;
         core_wen   = 1'b1;
         core_raddr = AW'($urandom_range(0, DEPTH - 1));
         core_waddr = AW'($urandom_range(0, DEPTH - 1));
         core_wdata = 64'hBAD0_0000_0000_0000 | 64'(i);
         host_valid = 1'b1;
         host_we    = i[0];
         cycle();
      end
      idle();
      check("fill init_done c17", init_done, 1);
      cycle();

      // ---------------------------------------------------- grant table
      host_rready = 1'b1;
      core_waddr  = CW;
      core_raddr  = CR;
      host_addr   = HA;
      for (int i = 0; i < 10; i++) begin
         core_ren   = vecs[i].c_ren;
         core_wen   = vecs[i].c_wen;
         host_valid = vecs[i].h_valid;
         host_we    = vecs[i].h_we;
         core_wdata = 64'h1000 + 64'(i);
         host_wdata = 64'h2000 + 64'(i);
         #1;
         check($sformatf("vec%0d host_ready", i), host_ready, vecs[i].e_ready);
         check($sformatf("vec%0d mem_wen", i), mem_wen, vecs[i].e_wen);
         if (vecs[i].e_wen) check($sformatf("vec%0d mem_waddr", i), mem_waddr, vecs[i].e_waddr);
         if (vecs[i].e_rd)  check($sformatf("vec%0d mem_raddr", i), mem_raddr, vecs[i].e_raddr);
         cycle();
      end
      idle();
      cycle();

      // ------------------------------------------- core write then read
      core_wen   = 1'b1;
      core_waddr = 4'd5;
      core_wdata = 64'hDEAD_BEEF;
      cycle();
      core_wen   = 1'b0;
      core_ren   = 1'b1;
      core_raddr = 4'd5;
      cycle();
      core_ren = 1'b0;
      check("core rd5 valid", core_rvalid, 1);
      check("core rd5 data", core_rdata, 64'hDEAD_BEEF);
      cycle();

      // ------------------------------------------------------- priority
      core_ren   = 1'b1;
      core_raddr = 4'd0;
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = 4'd5;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("prio blocked c%0d", i), host_ready, 0);
         cycle();
      end
      core_ren = 1'b0;
      #1;
      check("prio grant c4", host_ready, 1);
      cycle();
      idle();
      check("prio rdata", host_rdata, 64'hDEAD_BEEF);
      cycle();

      // ------------------------------------------------ host backpressure
      core_wen   = 1'b1;
      core_waddr = 4'd1;
      core_wdata = 64'h1111_1111_1111_1111;
      cycle();
      core_waddr = 4'd2;
      core_wdata = 64'h2222_2222_2222_2222;
      cycle();
      core_wen    = 1'b0;
      host_rready = 1'b0;
      host_valid  = 1'b1;
      host_we     = 1'b0;
      host_addr   = 4'd1;
      #1;
      check("bp accept1", host_ready, 1);
      cycle();
      host_addr = 4'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("bp blocked c%0d", i), host_ready, 0);
         check($sformatf("bp hold c%0d", i), host_rdata, 64'h1111_1111_1111_1111);
         cycle();
      end
      host_rready = 1'b1;
      #1;
      check("bp accept2", host_ready, 1);
      check("bp deliver1", host_rdata, 64'h1111_1111_1111_1111);
      cycle();
      host_valid = 1'b0;
      check("bp deliver2", host_rdata, 64'h2222_2222_2222_2222);
      cycle();

      // ------------------------------------------------------ collision
      core_wen   = 1'b1;
      core_waddr = 4'd7;
      core_wdata = 64'h22;
      cycle();
      core_wdata = 64'h11;
      host_valid = 1'b1;
      host_we    = 1'b0;
      host_addr  = 4'd7;
      #1;
      check("coll both granted", host_ready, 1);
      cycle();
      idle();
      check("coll old data", host_rdata, 64'h22);
      cycle();
      host_valid = 1'b1;
      cycle();
      idle();
      check("coll new data", host_rdata, 64'h11);
      cycle();

      // ------------------------------------------------------ randomized
      for (int i = 0; i < 400; i++) begin
         core_ren    = ($urandom_range(0, 2) == 0);
         core_raddr  = AW'($urandom_range(0, DEPTH - 1));
         core_wen    = ($urandom_range(0, 2) == 0);
         core_waddr  = AW'($urandom_range(0, DEPTH - 1));
         core_wdata  = {$urandom, $urandom};
         host_valid  = ($urandom_range(0, 1) == 1);
         host_we     = ($urandom_range(0, 2) == 0);
         host_addr   = AW'($urandom_range(0, DEPTH - 1));
         host_wdata  = {$urandom, $urandom};
         host_rready = ($urandom_range(0, 4) != 0);
         cycle();
      end
      idle();
      host_rready = 1'b1;
      cycle();

      // ---------------------------------------- reset during pending read
      host_rready = 1'b0;
      host_valid  = 1'b1;
      host_we     = 1'b0;
      host_addr   = 4'd3;
      cycle();
      host_valid = 1'b0;
      check("pre-rst host_rvalid", host_rvalid, 1);
      #2;
      reset = 1'b1;
      #1;
      check("midrst host_rvalid", host_rvalid, 0);
      check("midrst init_done", init_done, 0);
      check("midrst mem_wen", mem_wen, 1);
      check("midrst mem_waddr", mem_waddr, 0);
      check("midrst stall", host_stall_cycles, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i <= DEPTH; i++) cycle();
      host_rready = 1'b1;
      host_valid  = 1'b1;
      host_addr   = 4'd5;
      cycle();
      idle();
      check("post-rst refilled", host_rdata, 0);
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uram_port_scheduler
